ascon_p_serial_driver: RTL and testbench
========================================

ASCON_P_SERIAL_DRIVER -- requirements
Module: ascon_p_serial_driver

Interface
REQ-001 The block SHALL have parameter BW, default 64, giving the slice width; the state width SHALL be 5*BW.
REQ-002 The block SHALL have parameter WDOG, default 15, giving the maximum number of PERM cycles before timeout.
REQ-003 clk  input  1  single clock; all flops SHALL be clocked on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_state is valid.
REQ-006 in_ready  output  1  the block can accept a state.
REQ-007 in_state  input  5*BW  the state to permute; [5BW-1 -: BW] is word 0 and [BW-1:0] is word 4.
REQ-008 out_valid  output  1  out_state holds the permuted result.
REQ-009 out_ready  input  1  the consumer accepts out_state.
REQ-010 out_state  output  5*BW  the permuted state, with the same word order as in_state.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 err  output  1  sticky flag for a permutation timeout.
REQ-013 p_rstn  output  1  active-low clear to the permutation core; it SHALL be driven directly from a flop.
REQ-014 p_en  output  1  slice-load enable to the core.
REQ-015 p_en_inc  output  1  round-run enable to the core.
REQ-016 p_slice_idx  output  3  slice select to the core.
REQ-017 p_slice_in  output  BW  slice data to the core.
REQ-018 p_slice_out  input  BW  registered slice readback from the core; it is valid one cycle after p_slice_idx.
REQ-019 p_done  input  1  the core has finished its 12 rounds.

Function
REQ-020 The FSM SHALL have exactly six states: IDLE, CLR, LOAD, PERM, READ and OUT.
REQ-021 in_ready SHALL be 1 only in IDLE.
REQ-022 Acceptance SHALL occur when in_valid and in_ready are both 1 at a clock edge. On acceptance the block SHALL register in_state, clear err and go to CLR.
REQ-023 CLR SHALL last one cycle with p_rstn=0; in every other state p_rstn=1. CLR restarts the core's round counter.
REQ-024 LOAD SHALL last 5 cycles. In cycle i (i=0..4): p_en=1, p_slice_idx=i, p_slice_in=word i. After i=4 the FSM SHALL go to PERM.
REQ-025 In PERM: p_en=0 and p_en_inc=1. On the first edge where p_done=1, the FSM SHALL drop p_en_inc and go to READ.
REQ-026 A cycle counter SHALL run in PERM. If it reaches WDOG with p_done still 0, the block SHALL set err=1, set p_en_inc=0 and return to IDLE without asserting out_valid.
REQ-027 READ SHALL last 6 cycles. In cycle j (j=0..4) p_slice_idx=j. In cycle j+1, p_slice_out SHALL be captured into word j of out_state.
REQ-028 After the sixth READ cycle the FSM SHALL go to OUT.
REQ-029 In OUT, out_valid SHALL be 1 and out_state SHALL be held stable until out_ready=1. On that edge the FSM SHALL go to IDLE.
REQ-030 out_valid SHALL be 1 only in OUT. out_ready is ignored in all other states.
REQ-031 Latency from the acceptance edge to out_valid=1 SHALL be 1+5+N+6 cycles, where N is the number of PERM cycles.
REQ-032 In IDLE and OUT: p_en=0, p_en_inc=0, p_slice_idx=0 and p_slice_in=0.
REQ-033 p_en and p_en_inc SHALL never be 1 in the same cycle.
REQ-034 in_valid asserted while busy SHALL be ignored and SHALL not corrupt the stored state.
REQ-035 out_state SHALL retain its last value in IDLE.

Reset
REQ-036 While rstn=0, asynchronously: FSM=IDLE, in_ready=1, out_valid=0, busy=0, err=0, p_rstn=0, p_en=0, p_en_inc=0, p_slice_idx=0, p_slice_in=0, out_state=0, and all counters=0.
REQ-037 After rstn deasserts, p_rstn SHALL go to 1 on the first clock edge.
REQ-038 A reset asserted in any state SHALL abort the operation, with no partial out_valid.

Verification
REQ-039 Bench with the real core: in_state = 320'h0 accepted -> out_valid after 1+5+N+6 cycles; out_state matches the golden Ascon p12 of the all-zero state.
REQ-040 Two back-to-back operations, with the second in_valid held during the first -> the second is accepted only after the first OUT handshake; both results match the model, and CLR precedes each LOAD.
REQ-041 out_ready held at 0 for 10 cycles in OUT -> out_valid stays 1, out_state is stable and in_ready stays 0; on the release edge the FSM returns to IDLE.
REQ-042 Stub core with p_done tied to 0 -> err=1 after WDOG PERM cycles, FSM in IDLE, out_valid never 1; the next acceptance clears err.
REQ-043 rstn pulsed low during LOAD slice 2 and during READ -> all outputs take their reset values immediately; a new operation then completes correctly.
REQ-044 Assertions throughout all scenarios: no cycle with p_en and p_en_inc both 1, and out_valid=1 only in OUT.

Source files
------------

// File: rtl/ascon_p_serial_driver.sv
// rtl/ascon_p_serial_driver.sv - serial load/run/readback driver for an Ascon p12 core
module ascon_p_serial_driver #(
  parameter int BW   = 64,
  parameter int WDOG = 15
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5*BW-1:0] in_state,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5*BW-1:0] out_state,
  output logic            busy,
  output logic            err,
  output logic            p_rstn,
  output logic            p_en,
  output logic            p_en_inc,
  output logic [2:0]      p_slice_idx,
  output logic [BW-1:0]   p_slice_in,
  input  logic [BW-1:0]   p_slice_out,
  input  logic            p_done
);

  localparam int SW = 5 * BW;
  localparam int CW = $clog2(WDOG + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_PERM,
    S_READ,
    S_OUT
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   perm_q, perm_d;
  logic [SW-1:0]   in_q, in_d;
  logic [SW-1:0]   out_q, out_d;
  logic            err_q, err_d;
  logic            p_rstn_q;
  logic [BW-1:0]   load_word;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      perm_q   <= '0;
      in_q     <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
      p_rstn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      perm_q   <= perm_d;
      in_q     <= in_d;
      out_q    <= out_d;
      err_q    <= err_d;
      // Registered so the core clear is glitch-free and lasts exactly the CLR cycle.
      p_rstn_q <= (state_d != S_CLR);
    end
  end

  always_comb begin
    load_word = '0;
    for (int w = 0; w < 5; w++) begin
      if (idx_q == 3'(w)) load_word = in_q[SW-1-w*BW -: BW];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    perm_d      = perm_q;
    in_d        = in_q;
    out_d       = out_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    p_en        = 1'b0;
    p_en_inc    = 1'b0;
    p_slice_idx = '0;
    p_slice_in  = '0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in_d    = in_state;
          err_d   = 1'b0;
          idx_d   = '0;
          perm_d  = '0;
          state_d = S_CLR;
        end
      end

      S_CLR: begin
        idx_d   = '0;
        state_d = S_LOAD;
      end

      S_LOAD: begin
        p_en        = 1'b1;
        p_slice_idx = idx_q;
        p_slice_in  = load_word;
        if (idx_q == 3'd4) begin
          idx_d   = '0;
          perm_d  = '0;
          state_d = S_PERM;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      S_PERM: begin
        p_en_inc = 1'b1;
        if (p_done) begin
          idx_d   = '0;
          state_d = S_READ;
        end else if (perm_q == CW'(WDOG - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          perm_d = perm_q + 1'b1;
        end
      end

      S_READ: begin
        if (idx_q < 3'd5) p_slice_idx = idx_q;
        // Readback is registered in the core, so cycle j+1 carries slice j.
        for (int w = 0; w < 5; w++) begin
          if (idx_q == 3'(w + 1)) out_d[SW-1-w*BW -: BW] = p_slice_out;
        end
        if (idx_q == 3'd5) begin
          idx_d   = '0;
          state_d = S_OUT;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign out_state = out_q;
  assign p_rstn    = p_rstn_q;

endmodule

// File: tb/tb_ascon_p_serial_driver.sv
// tb/tb_ascon_p_serial_driver.sv - scoreboard bench for ascon_p_serial_driver with a stub core
module tb_ascon_p_serial_driver;

  localparam int BW   = 16;
  localparam int WDOG = 15;
  localparam int SW   = 5 * BW;
  localparam int LAT  = 25;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_state = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] out_state;
  logic          busy, err, p_rstn, p_en, p_en_inc, p_done;
  logic [2:0]    p_slice_idx;
  logic [BW-1:0] p_slice_in;
  logic [BW-1:0] p_slice_out = '0;

  always #5 clk = ~clk;

  ascon_p_serial_driver #(.BW(BW), .WDOG(WDOG)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy), .err(err), .p_rstn(p_rstn), .p_en(p_en), .p_en_inc(p_en_inc),
    .p_slice_idx(p_slice_idx), .p_slice_in(p_slice_in),
    .p_slice_out(p_slice_out), .p_done(p_done)
  );

  // Stub core: done after 12 run cycles, readback of slice i is word i ^ (0x1111*(i+1)).
  logic [BW-1:0] core_w [5];
  logic [4:0]    core_cnt = '0;
  logic          stub_hang = 1'b0;
  assign p_done = !stub_hang && (core_cnt >= 5'd12);

  function automatic logic [BW-1:0] key(input int i);
    return BW'(32'h1111 * (i + 1));
  endfunction

  always @(posedge clk) begin
    if (!p_rstn) core_cnt <= '0;
    else if (p_en_inc && core_cnt != 5'd31) core_cnt <= core_cnt + 5'd1;
    if (p_en && p_slice_idx < 3'd5) core_w[int'(p_slice_idx)] <= p_slice_in;
    if (p_slice_idx < 3'd5) p_slice_out <= core_w[int'(p_slice_idx)] ^ key(int'(p_slice_idx));
    else p_slice_out <= '0;
  end

  int n_chk = 0;
  int n_err = 0;
  logic [SW-1:0] exp_q [$];

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  int   cyc = 0;
  int   acc_at = 0;
  int   perm_n = 0;
  int   ov_seen = 0;
  logic ov_prev = 1'b0;
  logic prev_prstn = 1'b0;
  logic [SW-1:0] hold = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      chk("p_en_with_p_en_inc", SW'(p_en & p_en_inc), '0);
      chk("out_valid_outside_out", SW'(out_valid & (in_ready | ~busy)), '0);
      if (p_en && p_slice_idx == 3'd0) chk("clr_before_load", SW'(prev_prstn), '0);
      if (p_en_inc) perm_n++;
      if (in_valid && in_ready) begin
        acc_at = cyc + 1;
        perm_n = 0;
      end
      if (out_valid) ov_seen++;
      if (out_valid && !ov_prev) chk("latency", SW'(cyc - acc_at), SW'(LAT));
      if (out_valid && ov_prev) chk("out_stable", out_state, hold);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else chk("result", out_state, exp_q.pop_front());
      end
      hold       = out_state;
      ov_prev    = out_valid;
      prev_prstn = p_rstn;
    end else begin
      ov_prev    = 1'b0;
      prev_prstn = 1'b0;
    end
  end

  task automatic send(input logic [SW-1:0] v, input logic [SW-1:0] e,
                      input bit push, input bit expect_empty);
    int t = 0;
    @(posedge clk); #1;
    in_state = v;
    in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) fail_now("accept_wait");
    else begin
      if (expect_empty) chk("accept_after_prev_out", SW'(exp_q.size()), '0);
      if (push) exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) fail_now("wait_idle");
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ctrl"},
        SW'({in_ready, out_valid, busy, err, p_rstn, p_en, p_en_inc, p_slice_idx, p_slice_in}),
        SW'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0}));
    chk({name, "_out_state"}, out_state, '0);
  endtask

  localparam logic [SW-1:0] V1 = 80'h0000_0000_0000_0000_0000;
  localparam logic [SW-1:0] E1 = 80'h1111_2222_3333_4444_5555;
  localparam logic [SW-1:0] V2 = 80'h0123_4567_89AB_CDEF_FFFF;
  localparam logic [SW-1:0] E2 = 80'h1032_6745_BA98_89AB_AAAA;
  localparam logic [SW-1:0] V3 = 80'hAAAA_5555_0F0F_F0F0_1234;
  localparam logic [SW-1:0] E3 = 80'hBBBB_7777_3C3C_B4B4_4761;
  localparam logic [SW-1:0] V4 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [SW-1:0] E4 = 80'hEEEE_DDDD_CCCC_BBBB_AAAA;

  initial begin
    int t;
    int ov_before;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("p_rstn_after_reset", SW'(p_rstn), SW'(1));

    send(V1, E1, 1, 0);
    wait_idle();

    send(V2, E2, 1, 0);
    send(V3, E3, 1, 1);
    wait_idle();

    out_ready = 1'b0;
    send(V4, E4, 1, 0);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!out_valid) fail_now("stall_out_valid");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", SW'(out_valid), SW'(1));
      chk("stall_in_ready", SW'(in_ready), '0);
    end
    chk("stall_out_state", out_state, E4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_idle", SW'({in_ready, out_valid, busy}), SW'(3'b100));

    stub_hang = 1'b1;
    ov_before = ov_seen;
    send(V2, '0, 0, 0);
    t = 0;
    while (!err && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("timeout_err", SW'(err), SW'(1));
    chk("timeout_idle", SW'({in_ready, busy}), SW'(2'b10));
    chk("timeout_perm_cycles", SW'(perm_n), SW'(WDOG));
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_no_out_valid", SW'(ov_seen - ov_before), '0);
    stub_hang = 1'b0;
    send(V3, E3, 1, 0);
    chk("err_cleared_on_accept", SW'(err), '0);
    wait_idle();

    ov_before = ov_seen;
    send(V2, '0, 0, 0);
    t = 0;
    while (!(p_en && p_slice_idx == 3'd2) && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) fail_now("load_slice2_wait");
    rstn = 1'b0;
    #1;
    chk_reset_outputs("reset_in_load");
    @(negedge clk);
    rstn = 1'b1;

    send(V3, '0, 0, 0);
    t = 0;
    while (!p_en_inc && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    while (p_en_inc && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 60) fail_now("read_wait");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("reset_in_read");
    chk("no_partial_out_valid", SW'(ov_seen - ov_before), '0);
    @(negedge clk);
    rstn = 1'b1;

    send(V4, E4, 1, 0);
    wait_idle();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
